// File: rtl/ex_mem_pkg.sv
// Shared types and defaults for the EX->MEM elastic pipeline buffer.
package ex_mem_pkg;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEST_W = 4;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } ex_mem_ctrl_t;

  typedef struct packed {
    ex_mem_ctrl_t                ctrl;
    logic [DEFAULT_DATA_W-1:0]   alu_res;
    logic [DEFAULT_DATA_W-1:0]   val_rm;
    logic [DEFAULT_DEST_W-1:0]   dest;
  } ex_mem_entry_t;

  // A bubble must never write memory or the register file.
  function automatic ex_mem_ctrl_t gate_ctrl(input ex_mem_ctrl_t c, input logic v);
    return v ? c : '0;
  endfunction
endpackage

// File: rtl/ex_mem_entry_reg.sv
// One buffer slot: valid bit plus payload; kill drops the valid bit but keeps the payload.
module ex_mem_entry_reg #(
  parameter int W = 71
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_kill,
  input  logic         i_load,
  input  logic         i_valid,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);
  logic         r_valid;
  logic [W-1:0] r_q;

  // Payload only moves when a real entry lands, keeping toggle activity low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) r_q <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;
endmodule

// File: rtl/ex_mem_pipe_buf.sv
// EX->MEM valid/ready buffer, DEPTH 1 (register) or 2 (skid). Optional forwarding tap
// enabled by defining EX_MEM_FWD_TAP_EN.
module ex_mem_pipe_buf
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEST_W = DEFAULT_DEST_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
`ifdef EX_MEM_FWD_TAP_EN
  ,
  output logic              fwd_hit_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_res,
  output logic              fwd_is_load
`endif
);
  typedef struct packed {
    ex_mem_ctrl_t      ctrl;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
    logic [DEST_W-1:0] dest;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t                     w_in_e, w_hq, w_sq;
  logic                       w_hv, w_sv, w_in_xfer, w_out_xfer;
  logic [DEPTH-1:0]           w_vld, w_ld, w_vin;
  logic [DEPTH-1:0][EW-1:0]   w_q, w_d;

  assign w_in_e     = {in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_res, in_val_rm, in_dest};
  assign w_hv       = w_vld[0];
  assign w_hq       = entry_t'(w_q[0]);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = w_hv && out_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    ex_mem_entry_reg #(.W(EW)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .i_kill  (flush),
      .i_load  (w_ld[gi]),
      .i_valid (w_vin[gi]),
      .i_d     (w_d[gi]),
      .o_valid (w_vld[gi]),
      .o_q     (w_q[gi])
    );
  end

  if (DEPTH == 1) begin : g_d1
    assign w_sv = 1'b0;
    assign w_sq = '0;
    always_comb begin
      in_ready = !w_hv || out_ready;
      w_ld[0]  = w_out_xfer || !w_hv;
      w_vin[0] = w_in_xfer;
      w_d[0]   = w_in_e;
    end
  end else if (DEPTH == 2) begin : g_d2
    // Skid can only hold an entry while head does, so !skid_valid == (occupancy < 2)
    // and in_ready comes straight from a flop.
    assign w_sv     = w_vld[1];
    assign w_sq     = entry_t'(w_q[1]);
    assign in_ready = !w_sv;
    always_comb begin
      w_ld[0]  = w_out_xfer || !w_hv;
      w_vin[0] = w_sv || w_in_xfer;
      w_d[0]   = w_sv ? w_sq : w_in_e;
      w_ld[1]  = (w_out_xfer && w_sv) || (!w_out_xfer && w_hv && w_in_xfer);
      w_vin[1] = w_in_xfer;
      w_d[1]   = w_in_e;
    end
  end else begin : g_bad
    $fatal(1, "ex_mem_pipe_buf: DEPTH must be 1 or 2");
  end

  assign out_valid = w_hv;
  assign {out_wb_en, out_mem_r_en, out_mem_w_en} = gate_ctrl(w_hq.ctrl, w_hv);
  assign out_alu_res = w_hq.alu_res;
  assign out_val_rm  = w_hq.val_rm;
  assign out_dest    = w_hq.dest;
  assign occupancy   = {1'b0, w_hv} + {1'b0, w_sv};

`ifdef EX_MEM_FWD_TAP_EN
  // Newest writer wins: skid is younger than head.
  always_comb begin
    fwd_hit_valid = 1'b0;
    fwd_dest      = '0;
    fwd_res       = '0;
    fwd_is_load   = 1'b0;
    if (w_sv && w_sq.ctrl.wb_en) begin
      fwd_hit_valid = 1'b1;
      fwd_dest      = w_sq.dest;
      fwd_res       = w_sq.alu_res;
      fwd_is_load   = w_sq.ctrl.mem_r_en;
    end else if (w_hv && w_hq.ctrl.wb_en) begin
      fwd_hit_valid = 1'b1;
      fwd_dest      = w_hq.dest;
      fwd_res       = w_hq.alu_res;
      fwd_is_load   = w_hq.ctrl.mem_r_en;
    end
    if (flush) fwd_hit_valid = 1'b0;
  end
`endif
endmodule

// File: tb/tb_ex_mem_pipe_buf.sv
// Bench for ex_mem_pipe_buf: DEPTH=2 and DEPTH=1 instances share stimulus, each checked
// against a queue model of the buffer.
module tb_ex_mem_pipe_buf;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int EW = 3 + 2*DW + RW;
  typedef logic [EW-1:0] ent_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_wb_en = 1'b0, in_mem_r_en = 1'b0, in_mem_w_en = 1'b0;
  logic [DW-1:0] in_alu_res = '0, in_val_rm = '0;
  logic [RW-1:0] in_dest = '0;

  logic ir2, ov2, wb2, mr2, mw2, ir1, ov1, wb1, mr1, mw1;
  logic [DW-1:0] alu2, rm2, alu1, rm1;
  logic [RW-1:0] dest2, dest1;
  logic [1:0] occ2, occ1;
`ifdef EX_MEM_FWD_TAP_EN
  logic fh2, fl2, fh1, fl1;
  logic [RW-1:0] fd2, fd1;
  logic [DW-1:0] fr2, fr1;
`endif

  ex_mem_pipe_buf #(.DATA_W(DW), .DEST_W(RW), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .in_alu_res(in_alu_res), .in_val_rm(in_val_rm), .in_dest(in_dest),
    .out_valid(ov2), .out_ready(out_ready), .out_wb_en(wb2), .out_mem_r_en(mr2),
    .out_mem_w_en(mw2), .out_alu_res(alu2), .out_val_rm(rm2), .out_dest(dest2),
    .occupancy(occ2)
`ifdef EX_MEM_FWD_TAP_EN
    , .fwd_hit_valid(fh2), .fwd_dest(fd2), .fwd_res(fr2), .fwd_is_load(fl2)
`endif
  );

  ex_mem_pipe_buf #(.DATA_W(DW), .DEST_W(RW), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .in_alu_res(in_alu_res), .in_val_rm(in_val_rm), .in_dest(in_dest),
    .out_valid(ov1), .out_ready(out_ready), .out_wb_en(wb1), .out_mem_r_en(mr1),
    .out_mem_w_en(mw1), .out_alu_res(alu1), .out_val_rm(rm1), .out_dest(dest1),
    .occupancy(occ1)
`ifdef EX_MEM_FWD_TAP_EN
    , .fwd_hit_valid(fh1), .fwd_dest(fd1), .fwd_res(fr1), .fwd_is_load(fl1)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  ent_t q1[$];
  ent_t q2[$];
  ent_t w_in;
  logic [EW+3:0] act1, act2;

  assign w_in = {in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_res, in_val_rm, in_dest};
  // Data outputs are only meaningful while out_valid; control bits must read 0 when not.
  assign act2 = {ov2, ir2, occ2, wb2, mr2, mw2, ov2 ? {alu2, rm2, dest2} : {(EW-3){1'b0}}};
  assign act1 = {ov1, ir1, occ1, wb1, mr1, mw1, ov1 ? {alu1, rm1, dest1} : {(EW-3){1'b0}}};

  function automatic logic [EW+3:0] exp_vec(input int d);
    int n;
    ent_t h;
    logic ir;
    n = (d == 1) ? q1.size() : q2.size();
    h = '0;
    if (n > 0) h = (d == 1) ? q1[0] : q2[0];
    ir = (d == 1) ? (n == 0 || out_ready) : (n < 2);
    return {n > 0, ir, n[1:0], h};
  endfunction

  // FIFO of capacity DEPTH; flush empties it and drops any incoming entry.
  task automatic model_edge();
    logic inx, outx;
    if (!rst) begin
      q1.delete(); q2.delete();
      return;
    end
    inx  = in_valid && (q2.size() < 2);
    outx = (q2.size() > 0) && out_ready;
    if (flush) q2.delete();
    else begin
      if (outx) void'(q2.pop_front());
      if (inx) q2.push_back(w_in);
    end
    inx  = in_valid && (q1.size() == 0 || out_ready);
    outx = (q1.size() > 0) && out_ready;
    if (flush) q1.delete();
    else begin
      if (outx) void'(q1.pop_front());
      if (inx) q1.push_back(w_in);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] a, input logic [2:0] c,
                        input logic [RW-1:0] d);
    in_valid = v;
    {in_wb_en, in_mem_r_en, in_mem_w_en} = c;
    in_alu_res = a;
    in_val_rm = $urandom;
    in_dest = d;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, 32'hDEAD_BEEF, 3'b111, 4'hF);
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++;
      if ({ov2, occ2, wb2, mr2, mw2, alu2, rm2, dest2} !== '0) begin
        errs++;
        $display("FAIL reset_d2 cyc=%0d act=%h exp=0", c, {ov2, occ2, wb2, mr2, mw2, alu2, rm2, dest2});
      end
      vecs++;
      if ({ov1, occ1, wb1, mr1, mw1, alu1, rm1, dest1} !== '0) begin
        errs++;
        $display("FAIL reset_d1 cyc=%0d act=%h exp=0", c, {ov1, occ1, wb1, mr1, mw1, alu1, rm1, dest1});
      end
      tick();
    end
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    vecs++;
    if ({ir2, ir1} !== 2'b11) begin
      errs++;
      $display("FAIL reset_release_in_ready act=%b exp=11", {ir2, ir1});
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) set_in(1'b1, 32'h10 + k, 3'b100, 4'(k));
      else in_valid = 1'b0;
      #1;
      vecs++;
      if (act2 !== exp_vec(2) || ir2 !== 1'b1) begin
        errs++;
        $display("FAIL stream_d2 k=%0d act=%h exp=%h", k, act2, exp_vec(2));
      end
      vecs++;
      if (act1 !== exp_vec(1)) begin
        errs++;
        $display("FAIL stream_d1 k=%0d act=%h exp=%h", k, act1, exp_vec(1));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] vals [3];
    int idx;
    vals = '{32'hA1, 32'hA2, 32'hA3};
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) out_ready = 1'b1;
      if (idx < 3) set_in(1'b1, vals[idx], 3'b100, 4'(idx));
      else in_valid = 1'b0;
      #1;
      vecs++;
      if (act2 !== exp_vec(2)) begin
        errs++;
        $display("FAIL skid_d2 c=%0d act=%h exp=%h", c, act2, exp_vec(2));
      end
      vecs++;
      if (act1 !== exp_vec(1)) begin
        errs++;
        $display("FAIL skid_d1 c=%0d act=%h exp=%h", c, act1, exp_vec(1));
      end
      if (in_valid && ir2) idx++;
      tick();
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      flush = (c == 2);
      if (c < 2) set_in(1'b1, 32'hB0 + c, 3'b001, 4'(c));
      else if (c == 2) begin
        set_in(1'b1, 32'hF1F1, 3'b001, 4'h7);
        out_ready = 1'b1;
      end else in_valid = 1'b0;
      #1;
      vecs++;
      if (act2 !== exp_vec(2)) begin
        errs++;
        $display("FAIL flush_d2 c=%0d act=%h exp=%h", c, act2, exp_vec(2));
      end
      vecs++;
      if (act1 !== exp_vec(1)) begin
        errs++;
        $display("FAIL flush_d1 c=%0d act=%h exp=%h", c, act1, exp_vec(1));
      end
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_in(1'b1, 32'h55, 3'b100, 4'h3);
    tick();
    in_valid = 1'b0;
    #1;
    vecs++;
    if (act2 !== exp_vec(2) || act1 !== exp_vec(1)) begin
      errs++;
      $display("FAIL async_pre act=%h/%h exp=%h/%h", act2, act1, exp_vec(2), exp_vec(1));
    end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({ov2, ov1, occ2, occ1} !== 6'b0) begin
      errs++;
      $display("FAIL async_reset_mid act=%b exp=000000", {ov2, ov1, occ2, occ1});
    end
    tick();
    rst = 1'b1;
    #1;
    vecs++;
    if (act2 !== exp_vec(2) || act1 !== exp_vec(1)) begin
      errs++;
      $display("FAIL async_post act=%h/%h exp=%h/%h", act2, act1, exp_vec(2), exp_vec(1));
    end
  endtask

  task automatic test_depth1_toggle();
    int idx;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      out_ready = (c % 2 == 0) || (c >= 4);
      if (idx < 4) set_in(1'b1, 32'h40 + idx, 3'b100, 4'(idx));
      else in_valid = 1'b0;
      #1;
      vecs++;
      if (act1 !== exp_vec(1)) begin
        errs++;
        $display("FAIL d1_toggle c=%0d act=%h exp=%h", c, act1, exp_vec(1));
      end
      vecs++;
      if (act2 !== exp_vec(2)) begin
        errs++;
        $display("FAIL d2_toggle c=%0d act=%h exp=%h", c, act2, exp_vec(2));
      end
      if (q1.size() > 0) begin
        out_ready = ~out_ready;
        #1;
        vecs++;
        if (ir1 !== out_ready || ir2 !== (q2.size() < 2)) begin
          errs++;
          $display("FAIL in_ready_comb act=%b%b exp=%b%b", ir1, ir2, out_ready, q2.size() < 2);
        end
        out_ready = ~out_ready;
        #1;
      end
      if (in_valid && ir1) idx++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      set_in(1'($urandom), $urandom, 3'($urandom), 4'($urandom));
      #1;
      vecs++;
      if (act2 !== exp_vec(2)) begin
        errs++;
        $display("FAIL random_d2 c=%0d act=%h exp=%h", c, act2, exp_vec(2));
      end
      vecs++;
      if (act1 !== exp_vec(1)) begin
        errs++;
        $display("FAIL random_d1 c=%0d act=%h exp=%h", c, act1, exp_vec(1));
      end
      tick();
    end
    flush = 1'b0;
  endtask

`ifdef EX_MEM_FWD_TAP_EN
  function automatic logic [RW+DW+1:0] exp_fwd(input int d);
    logic [RW+DW+1:0] r;
    ent_t e;
    int n;
    r = '0;
    n = (d == 1) ? q1.size() : q2.size();
    for (int i = n - 1; i >= 0; i--) begin
      e = (d == 1) ? q1[i] : q2[i];
      if (e[EW-1]) begin
        r = {1'b1, e[RW-1:0], e[EW-4 -: DW], e[EW-2]};
        break;
      end
    end
    if (flush) r = '0;
    return r;
  endfunction

  task automatic test_fwd_tap();
    logic [RW+DW+1:0] a2, a1;
    flush = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b1, 32'h1234, 3'b110, 4'd5);
    tick();
    in_valid = 1'b0;
    #1;
    vecs++;
    if ({fh2, fd2, fl2, fh1, fd1, fl1} !== {1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1}) begin
      errs++;
      $display("FAIL fwd_load act=%b exp=%b", {fh2, fd2, fl2, fh1, fd1, fl1}, 12'b1_0101_1_1_0101_1);
    end
    for (int c = 0; c < 100; c++) begin
      flush = ($urandom_range(0, 7) == 0);
      out_ready = 1'($urandom);
      set_in(1'($urandom), $urandom, 3'($urandom), 4'($urandom));
      #1;
      a2 = {fh2, fh2 ? {fd2, fr2, fl2} : {(RW+DW+1){1'b0}}};
      a1 = {fh1, fh1 ? {fd1, fr1, fl1} : {(RW+DW+1){1'b0}}};
      vecs++;
      if (a2 !== exp_fwd(2) || a1 !== exp_fwd(1)) begin
        errs++;
        $display("FAIL fwd_rand c=%0d act=%h/%h exp=%h/%h", c, a2, a1, exp_fwd(2), exp_fwd(1));
      end
      tick();
    end
    flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_depth1_toggle();
    test_random();
`ifdef EX_MEM_FWD_TAP_EN
    test_fwd_tap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
